// File: rtl/snn_array_npe.sv
// N-lane spiking-neuron integration array: one AER event fetches a packed weight word
// and accumulates time-scaled weights into per-lane saturating membrane potentials.
module snn_array_npe #(
  parameter int NUM_PE           = 8,
  parameter int TIME_W           = 8,
  parameter int WEIGHT_W         = 8,
  parameter int ADDR_W           = 10,
  parameter int ACC_W            = 32,
  parameter int BRAM_LAT         = 1,
  parameter int WATCHDOG_TIMEOUT = 10000
) (
  input  logic                         local_clk,
  input  logic                         rst_n,
  input  logic                         i_clk_en,
  input  logic                         i_aer_req,
  input  logic signed [TIME_W-1:0]     i_aer_time,
  input  logic [ADDR_W-1:0]            i_aer_addr,
  input  logic signed [TIME_W-1:0]     i_t_min,
  input  logic [NUM_PE-1:0]            i_pe_enable,
  input  logic [NUM_PE-1:0]            i_reset_potential,
  output logic                         o_bram_en,
  output logic [ADDR_W-1:0]            o_bram_addr,
  input  logic [NUM_PE*WEIGHT_W-1:0]   i_bram_data,
  output logic                         o_aer_ack,
  output logic                         o_busy,
  output logic                         o_error,
  output logic [NUM_PE-1:0]            o_sat,
  output logic [NUM_PE*ACC_W-1:0]      o_potential_flat
);

  localparam int DELTA_W = TIME_W + 1;
  localparam int PROD_W  = WEIGHT_W + TIME_W + 1;
  localparam int LAT_W   = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;
  localparam int WD_W    = $clog2(WATCHDOG_TIMEOUT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(BRAM_LAT - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WATCHDOG_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ACK, S_ERROR} state_t;

  state_t                    state_q;
  logic signed [TIME_W-1:0]  time_q;
  logic [ADDR_W-1:0]         bram_addr_q;
  logic [LAT_W-1:0]          lat_q;
  logic [WD_W-1:0]           wd_q;
  logic                      bram_en_q;
  logic                      ack_q;
  logic                      err_q;

  logic [NUM_PE-1:0][ACC_W-1:0] pot_q, pot_d;
  logic [NUM_PE-1:0]            sat_q, sat_d;

  logic signed [DELTA_W-1:0] delta;
  logic signed [PROD_W-1:0]  prod_w [NUM_PE];
  logic signed [ACC_W:0]     sum_w  [NUM_PE];
  logic                      upd;

  function automatic logic sat_ovf(input logic signed [ACC_W:0] s);
    return s[ACC_W] != s[ACC_W-1];
  endfunction

  function automatic logic [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
    if (!sat_ovf(s)) return s[ACC_W-1:0];
    return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  always_ff @(posedge local_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      time_q      <= '0;
      bram_addr_q <= '0;
      lat_q       <= '0;
      wd_q        <= '0;
      bram_en_q   <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else if (i_clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (i_aer_req) begin
            time_q      <= i_aer_time;
            bram_addr_q <= i_aer_addr;
            bram_en_q   <= 1'b1;
            state_q     <= S_FETCH;
          end
        end
        S_FETCH: begin
          bram_en_q <= 1'b0;
          lat_q     <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_q == LAT_LAST) begin
            ack_q   <= 1'b1;
            wd_q    <= '0;
            state_q <= S_ACK;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        S_ACK: begin
          if (!i_aer_req) begin
            ack_q   <= 1'b0;
            state_q <= S_IDLE;
          end else if (wd_q == WD_LAST) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_ERROR: begin
          if (!i_aer_req) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // BRAM word is valid only on the final WAIT cycle.
  assign upd   = i_clk_en && (state_q == S_WAIT) && (lat_q == LAT_LAST);
  assign delta = DELTA_W'(time_q) - DELTA_W'(i_t_min);

  for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
    logic signed [WEIGHT_W-1:0] w;
    assign w         = signed'(i_bram_data[g*WEIGHT_W +: WEIGHT_W]);
    assign prod_w[g] = PROD_W'(w) * PROD_W'(delta);
    assign sum_w[g]  = (ACC_W+1)'(signed'(pot_q[g])) + (ACC_W+1)'(prod_w[g]);
  end

  always_comb begin
    pot_d = pot_q;
    sat_d = sat_q;
    for (int k = 0; k < NUM_PE; k++) begin
      if (i_reset_potential[k]) begin
        pot_d[k] = '0;
        sat_d[k] = 1'b0;
      end else if (upd && i_pe_enable[k]) begin
        pot_d[k] = sat_acc(sum_w[k]);
        if (sat_ovf(sum_w[k])) sat_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge local_clk or negedge rst_n) begin
    if (!rst_n) begin
      pot_q <= '0;
      sat_q <= '0;
    end else if (i_clk_en) begin
      pot_q <= pot_d;
      sat_q <= sat_d;
    end
  end

  assign o_bram_en        = bram_en_q;
  assign o_bram_addr      = bram_addr_q;
  assign o_aer_ack        = ack_q;
  assign o_busy           = (state_q != S_IDLE);
  assign o_error          = err_q;
  assign o_sat            = sat_q;
  assign o_potential_flat = pot_q;

endmodule
